// File: rtl/router_1xn_if.sv
// ---------------------------------------------------------------------------
// router_1xn_if : packet and read-side bus of the 1xN packet router.
//
// Signals
//   pkt_valid  : data_in carries a packet byte
//   data_in    : packet byte (header, payload or parity)
//   busy       : input stall. Handshake: a byte is transferred on a rising
//                edge iff pkt_valid=1 and busy=0 during the preceding cycle.
//                busy never depends on pkt_valid.
//   err        : 1-cycle pulse, parity mismatch on a delivered packet
//   drop       : 1-cycle pulse, packet discarded
//   read_enb   : per-channel read request. A read happens on an edge iff
//                read_enb[i]=1 and vld_out[i]=1.
//   vld_out    : per-channel FIFO non-empty
//   data_out   : per-channel read data, channel i at [i*DATA_W +: DATA_W]
//   soft_reset : per-channel 1-cycle pulse, channel flushed by timeout
//
// Modports
//   slave  : the router itself
//   master : packet source plus downstream readers (testbench side)
// ---------------------------------------------------------------------------
interface router_1xn_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
) ();
  logic                          pkt_valid;
  logic [DATA_W-1:0]             data_in;
  logic                          busy;
  logic                          err;
  logic                          drop;
  logic [NUM_PORTS-1:0]          read_enb;
  logic [NUM_PORTS-1:0]          vld_out;
  logic [NUM_PORTS*DATA_W-1:0]   data_out;
  logic [NUM_PORTS-1:0]          soft_reset;

  modport slave (
    input  pkt_valid, data_in, read_enb,
    output busy, err, drop, vld_out, data_out, soft_reset
  );

  modport master (
    output pkt_valid, data_in, read_enb,
    input  busy, err, drop, vld_out, data_out, soft_reset
  );
endinterface

// File: rtl/router_1xn.sv
// ---------------------------------------------------------------------------
// router_1xn : byte-serial 1-to-NUM_PORTS packet router.
//
// A packet is a header (addr = header[1:0], length L = header[DATA_W-1:2]),
// L payload bytes and one parity byte (XOR of header and payload). Packets
// are steered into a per-channel FIFO; packets for a nonexistent channel, or
// whose channel is flushed by the read timeout mid-packet, are swallowed and
// flagged with drop.
//
// Ports
//   clock     : rising-edge clock
//   resetn    : asynchronous active-low reset
//   bus       : router_1xn_if.slave (packet input, status, read side)
//   dbg_state : current FSM state encoding
// ---------------------------------------------------------------------------
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic          clock,
  input  logic          resetn,
  router_1xn_if.slave   bus,
  output logic [2:0]    dbg_state
);

  localparam int LEN_W = DATA_W - 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [2:0]      NP3     = 3'(NUM_PORTS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_WR  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_CHECK   = 3'd4,
    S_DROP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          dest_q, dest_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   par_acc_q, par_acc_d;
  logic [DATA_W-1:0]   par_byte_q, par_byte_d;
  logic                drop_q, drop_d;

  logic [DATA_W-1:0]   mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d    [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]    wr_ptr_d [NUM_PORTS];
  logic [PTR_W-1:0]    rd_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]    rd_ptr_d [NUM_PORTS];
  logic [CNT_W-1:0]    count_q  [NUM_PORTS];
  logic [CNT_W-1:0]    count_d  [NUM_PORTS];
  logic [DATA_W-1:0]   dout_q   [NUM_PORTS];
  logic [DATA_W-1:0]   dout_d   [NUM_PORTS];
  logic [TO_W-1:0]     to_cnt_q [NUM_PORTS];
  logic [TO_W-1:0]     to_cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] soft_q, soft_d;

  logic [NUM_PORTS-1:0] full, empty, flush, wr_sel, rd_sel;
  logic                 full_dest, flush_dest, busy, accept, wr_en;
  logic [DATA_W-1:0]    wr_data;

  // Channel status, all from registered state so busy stays stable between
  // edges. A flush fires on the edge that ends the TIMEOUT-th unread cycle.
  always_comb begin
    full  = '0;
    empty = '0;
    flush = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
      empty[i] = (count_q[i] == '0);
      flush[i] = !empty[i] && !bus.read_enb[i] && (to_cnt_q[i] == TO_LAST);
    end
  end

  always_comb begin
    full_dest  = 1'b0;
    flush_dest = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dest_q == 2'(i)) begin
        full_dest  = full[i];
        flush_dest = flush[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_HDR_WR, S_CHECK:    busy = 1'b1;
      S_PAYLOAD, S_PARITY:  busy = full_dest;
      default:              busy = 1'b0;
    endcase
  end

  assign accept = bus.pkt_valid && !busy;

  // FSM next state. The header is held in par_acc_q until it is written,
  // since nothing has been XORed into the accumulator before HDR_WR ends.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    par_acc_d  = par_acc_q;
    par_byte_d = par_byte_q;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = bus.data_in;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          dest_d    = bus.data_in[1:0];
          len_d     = bus.data_in[DATA_W-1:2];
          par_acc_d = bus.data_in;
          state_d   = ({1'b0, bus.data_in[1:0]} < NP3) ? S_HDR_WR : S_DROP;
        end
      end
      S_HDR_WR: begin
        wr_data = par_acc_q;
        if (flush_dest) begin
          state_d = S_DROP;
        end else if (!full_dest) begin
          wr_en   = 1'b1;
          state_d = (len_q == '0) ? S_PARITY : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        wr_en = accept;
        if (accept) begin
          par_acc_d = par_acc_q ^ bus.data_in;
          len_d     = len_q - LEN_W'(1);
        end
        // On a flush the byte taken this edge is already counted off len,
        // so DROP resumes with exactly the bytes still outstanding.
        if (flush_dest)                         state_d = S_DROP;
        else if (accept && len_q == LEN_W'(1))  state_d = S_PARITY;
      end
      S_PARITY: begin
        wr_en = accept;
        if (accept) par_byte_d = bus.data_in;
        if (flush_dest) begin
          if (accept) begin
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end else if (accept) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      S_DROP: begin
        // len counts remaining payload; the byte taken at len=0 is parity.
        if (accept) begin
          if (len_q == '0) begin
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d = len_q - LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-channel FIFO and timeout; a flush overrides any read or write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    to_cnt_d = to_cnt_q;
    soft_d   = '0;
    wr_sel   = '0;
    rd_sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wr_sel[i] = wr_en && (dest_q == 2'(i)) && !full[i];
      rd_sel[i] = bus.read_enb[i] && !empty[i];
      soft_d[i] = flush[i];
      if (flush[i]) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
        to_cnt_d[i] = '0;
      end else begin
        if (wr_sel[i]) begin
          mem_d[i][wr_ptr_q[i]] = wr_data;
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        end
        if (rd_sel[i]) begin
          dout_d[i]   = mem_q[i][rd_ptr_q[i]];
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        end
        count_d[i]  = count_q[i] + CNT_W'(wr_sel[i]) - CNT_W'(rd_sel[i]);
        to_cnt_d[i] = (!empty[i] && !bus.read_enb[i]) ? to_cnt_q[i] + TO_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      par_acc_q  <= '0;
      par_byte_q <= '0;
      drop_q     <= 1'b0;
      soft_q     <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        dout_q[i]   <= '0;
        to_cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      par_acc_q  <= par_acc_d;
      par_byte_q <= par_byte_d;
      drop_q     <= drop_d;
      soft_q     <= soft_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the counters.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.data_out[i*DATA_W +: DATA_W] = dout_q[i];
    end
  end

  assign bus.busy       = busy;
  assign bus.err        = (state_q == S_CHECK) && (par_byte_q != par_acc_q);
  assign bus.drop       = drop_q;
  assign bus.vld_out    = ~empty;
  assign bus.soft_reset = soft_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_router_1xn.sv
// ---------------------------------------------------------------------------
// tb_router_1xn : self-checking bench for router_1xn (8-bit, 3 ports,
// depth 16, timeout 30). Inputs are driven and outputs sampled 1 time unit
// after the rising edge; the random-phase monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_router_1xn;
  localparam int DW = 8;
  localparam int NP = 3;
  localparam int FD = 16;
  localparam int TO = 30;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] dbg_state;

  router_1xn_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

  router_1xn #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int drop_cnt = 0;

  always @(negedge clock) begin
    if (bus.err  === 1'b1) err_cnt++;
    if (bus.drop === 1'b1) drop_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.pkt_valid = 1'b1;
    bus.data_in   = b;
    t = 0;
    while (bus.busy !== 1'b0 && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_stall: busy held for %0d cycles, limit 200", t);
    end
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic read_one(input int p, input logic [7:0] exp, input string name);
    bus.read_enb[p] = 1'b1;
    tick();
    bus.read_enb[p] = 1'b0;
    chk(name, 32'(bus.data_out[p*DW +: DW]), 32'(exp));
  endtask

  // ---- vector table: packet bytes (first byte in the MSBs) and outcome ----
  typedef struct {
    logic [63:0] bytes;
    int          n;
    logic [2:0]  exp_vld;
    int          exp_err;
    int          exp_drop;
  } vec_t;

  vec_t vecs[9];

  // ---- random-phase scoreboard ----
  logic [7:0]    exp_q[NP][$];
  logic [7:0]    exp_b;
  logic [NP-1:0] pend = '0;
  bit            mon_en  = 1'b0;
  bit            rand_on = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      for (int i = 0; i < NP; i++) begin
        if (pend[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_underflow: port %0d popped %0h with nothing expected",
                     i, bus.data_out[i*DW +: DW]);
          end else begin
            exp_b = exp_q[i].pop_front();
            chk("rand_data", 32'(bus.data_out[i*DW +: DW]), 32'(exp_b));
          end
        end
      end
      pend = bus.read_enb & bus.vld_out;
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_on) begin
      for (int i = 0; i < NP; i++) bus.read_enb[i] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, d0, port, n, t;
    int addr, len, exp_err_r, exp_drop_r;
    logic [7:0] b, par, hdr;
    bit bad;

    vecs[0] = '{64'h0D11_2233_0D00_0000, 5, 3'b010, 0, 0};
    vecs[1] = '{64'h0D11_2233_FF00_0000, 5, 3'b010, 1, 0};
    vecs[2] = '{64'h07AA_AD00_0000_0000, 3, 3'b000, 0, 1};
    vecs[3] = '{64'h0000_0000_0000_0000, 2, 3'b001, 0, 0};
    vecs[4] = '{64'h065A_5C00_0000_0000, 3, 3'b100, 0, 0};
    vecs[5] = '{64'h0B01_0208_0000_0000, 4, 3'b000, 0, 1};
    vecs[6] = '{64'h0577_0000_0000_0000, 3, 3'b010, 1, 0};
    vecs[7] = '{64'h0202_0000_0000_0000, 2, 3'b100, 0, 0};
    vecs[8] = '{64'h0C10_2030_0C00_0000, 5, 3'b001, 0, 0};

    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = '0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_vld",   32'(bus.vld_out), 0);
    chk("rst_dout",  32'(bus.data_out), 0);
    chk("rst_soft",  32'(bus.soft_reset), 0);
    chk("rst_state", 32'(dbg_state), 0);
    resetn = 1'b1;
    tick();

    // ---- table-driven packets ----
    for (int v = 0; v < 9; v++) begin
      e0 = err_cnt;
      d0 = drop_cnt;
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].bytes[63-8*k -: 8]);
      repeat (3) tick();
      chk("vec_vld",  32'(bus.vld_out), 32'(vecs[v].exp_vld));
      chk("vec_err",  32'(err_cnt - e0), 32'(vecs[v].exp_err));
      chk("vec_drop", 32'(drop_cnt - d0), 32'(vecs[v].exp_drop));
      if (vecs[v].exp_vld != 3'b000) begin
        port = vecs[v].exp_vld[0] ? 0 : (vecs[v].exp_vld[1] ? 1 : 2);
        for (int k = 0; k < vecs[v].n; k++) read_one(port, vecs[v].bytes[63-8*k -: 8], "vec_data");
      end
      chk("vec_drained", 32'(bus.vld_out), 0);
    end

    // ---- full FIFO stalls the parity byte until one read ----
    e0 = err_cnt;
    send_byte(8'h3C);
    for (int k = 1; k <= 15; k++) send_byte(8'(k));
    chk("full_busy", 32'(bus.busy), 1);
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h3C;
    tick();
    tick();
    chk("full_busy_hold", 32'(bus.busy), 1);
    read_one(0, 8'h3C, "full_head");
    chk("full_unblock", 32'(bus.busy), 0);
    tick();
    bus.pkt_valid = 1'b0;
    chk("full_check_busy", 32'(bus.busy), 1);
    chk("full_check_err", 32'(bus.err), 0);
    tick();
    for (int k = 1; k <= 15; k++) read_one(0, 8'(k), "full_data");
    read_one(0, 8'h3C, "full_parity");
    chk("full_err_total", 32'(err_cnt - e0), 0);
    chk("full_drained", 32'(bus.vld_out), 0);

    // ---- timeout flush of an unread complete packet ----
    e0 = err_cnt;
    d0 = drop_cnt;
    send_byte(8'h02);
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h02;
    t = 0;
    while (bus.vld_out[2] !== 1'b1 && t < 10) begin
      tick();
      t++;
    end
    tick();
    bus.pkt_valid = 1'b0;
    n = 1;
    while (bus.soft_reset[2] !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 30);
    chk("to_vld", 32'(bus.vld_out), 0);
    tick();
    chk("to_soft_pulse", 32'(bus.soft_reset), 0);
    chk("to_err", 32'(err_cnt - e0), 0);
    chk("to_drop", 32'(drop_cnt - d0), 0);

    // ---- timeout flush mid-payload: rest of packet is dropped ----
    e0 = err_cnt;
    d0 = drop_cnt;
    send_byte(8'h1E);
    send_byte(8'h01);
    send_byte(8'h02);
    n = 0;
    while (bus.soft_reset[2] !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk("mid_flush_seen", 32'(bus.soft_reset[2]), 1);
    chk("mid_state_drop", 32'(dbg_state), 5);
    chk("mid_vld", 32'(bus.vld_out), 0);
    for (int k = 3; k <= 7; k++) send_byte(8'(k));
    send_byte(8'h00);
    repeat (2) tick();
    chk("mid_drop", 32'(drop_cnt - d0), 1);
    chk("mid_err", 32'(err_cnt - e0), 0);
    chk("mid_idle", 32'(dbg_state), 0);

    // ---- asynchronous reset mid-payload ----
    send_byte(8'h0D);
    send_byte(8'h11);
    tick();
    chk("arst_pre_vld", 32'(bus.vld_out), 32'b010);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_err",  32'(bus.err), 0);
    chk("arst_drop", 32'(bus.drop), 0);
    chk("arst_vld",  32'(bus.vld_out), 0);
    chk("arst_soft", 32'(bus.soft_reset), 0);
    chk("arst_dout", 32'(bus.data_out), 0);
    chk("arst_state", 32'(dbg_state), 0);
    tick();
    resetn = 1'b1;
    tick();
    e0 = err_cnt;
    send_byte(8'h0D);
    chk("lat_hdr_early", 32'(bus.vld_out), 0);
    tick();
    chk("lat_hdr_vld", 32'(bus.vld_out), 32'b010);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h0D);
    tick();
    read_one(1, 8'h0D, "post_rst_data");
    read_one(1, 8'h11, "post_rst_data");
    read_one(1, 8'h22, "post_rst_data");
    read_one(1, 8'h33, "post_rst_data");
    read_one(1, 8'h0D, "post_rst_data");
    chk("post_rst_vld", 32'(bus.vld_out), 0);
    chk("post_rst_err", 32'(err_cnt - e0), 0);

    // ---- randomized packets against the queue model ----
    e0 = err_cnt;
    d0 = drop_cnt;
    exp_err_r  = 0;
    exp_drop_r = 0;
    mon_en  = 1'b1;
    rand_on = 1'b1;
    for (int p = 0; p < 40; p++) begin
      addr = $urandom_range(0, 3);
      len  = $urandom_range(0, 6);
      hdr  = {6'(len), 2'(addr)};
      par  = hdr;
      if (addr < NP) exp_q[addr].push_back(hdr);
      send_byte(hdr);
      for (int k = 0; k < len; k++) begin
        b   = 8'($urandom);
        par = par ^ b;
        if (addr < NP) exp_q[addr].push_back(b);
        if ($urandom_range(0, 3) == 0) tick();
        send_byte(b);
      end
      bad = ($urandom_range(0, 3) == 0);
      if (bad) par = par ^ 8'($urandom_range(1, 255));
      if (addr < NP) begin
        exp_q[addr].push_back(par);
        if (bad) exp_err_r++;
      end else begin
        exp_drop_r++;
      end
      send_byte(par);
    end
    t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 1000) begin
      tick();
      t++;
    end
    rand_on = 1'b0;
    tick();
    bus.read_enb = '0;
    repeat (2) tick();
    mon_en = 1'b0;
    chk("rand_left", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);
    chk("rand_vld", 32'(bus.vld_out), 0);
    chk("rand_err", 32'(err_cnt - e0), 32'(exp_err_r));
    chk("rand_drop", 32'(drop_cnt - d0), 32'(exp_drop_r));
    chk("rand_soft", 32'(bus.soft_reset), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
Parametrised next-generation packet router: one byte-serial input, NUM_PORTS output channels, each with its own FIFO. The header addresses the destination and gives the payload length. Over the fixed 1x3 router it adds:
- length-counted framing with input stalls allowed mid-packet;
- more than one packet may queue in each FIFO;
- invalid-address and flushed packets are dropped and flagged;
- timeout-flush length is a parameter.

It sits between the packet source and up to four downstream readers.

Parameters:
DATA_W, 8, byte width of data_in/data_out; ≥4.
NUM_PORTS, 3, output channels; 2..4 (address field is always header[1:0]).
FIFO_DEPTH, 16, entries per channel FIFO; power of 2, ≥4.
TIMEOUT, 30, consecutive unread-valid cycles before a channel is flushed; ≥2.

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous, active-low reset
pkt_valid  in  1  data_in carries a packet byte
data_in  in  DATA_W  packet byte
busy  out  1  input stall; a byte is accepted on an edge iff pkt_valid=1 and busy=0
err  out  1  1-cycle pulse: parity mismatch
drop  out  1  1-cycle pulse: packet discarded
read_enb  in  NUM_PORTS  per-channel read request
vld_out  out  NUM_PORTS  per-channel FIFO non-empty
data_out  out  NUM_PORTS*DATA_W  per-channel read data, channel i at [i*DATA_W +: DATA_W]
soft_reset  out  NUM_PORTS  1-cycle pulse: channel flushed by timeout

Behaviour:
- Reset (async, resetn=0): FSM to IDLE; all FIFOs empty with pointers 0. Outputs busy, err, drop, vld_out, soft_reset and data_out are all 0. All counters are 0.
- Packet format:
  - header: addr = header[1:0], L = header[DATA_W-1:2];
  - then L payload bytes; L=0 is legal;
  - then one parity byte, which must equal the XOR of the header and all payload bytes.
- Bytes may be separated by pkt_valid=0 gaps; the FSM holds its state during gaps.
- FSM states:
  - IDLE: busy=0. On header accept, latch dest=addr, len=L, parity_acc=header. Go to HDR_WR if addr<NUM_PORTS, else DROP.
  - HDR_WR: busy=1. On the first edge where the dest FIFO is not full, write the latched header and go to PAYLOAD (or PARITY if len=0).
  - PAYLOAD: busy=full[dest]. Each accepted byte is written to FIFO[dest] on the same edge, XORed into parity_acc, and decrements len. Go to PARITY when the last payload byte is accepted.
  - PARITY: busy=full[dest]. The accepted byte is written to FIFO[dest] and latched; go to CHECK.
  - CHECK: busy=1 for exactly 1 cycle. err=1 this cycle iff the latched parity differs from parity_acc. Go to IDLE.
  - DROP: busy=0. Consume the remaining bytes (len payload bytes plus 1 parity byte) without writing any FIFO. drop=1 in the cycle after the final byte is accepted. Go to IDLE.
- busy is combinational from state and full[dest]. A read on the same edge does not unblock a write to a full FIFO.
- FIFO i:
  - vld_out[i] = ~empty[i].
  - If read_enb[i]=1 and vld_out[i]=1, data_out[i] updates to the head entry at that edge and the entry is popped.
  - Otherwise data_out[i] holds its value.
  - Full when it holds FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous read and write on a non-full FIFO are both performed.
- Timeout, channel i:
  - Counter increments each cycle vld_out[i]=1 and read_enb[i]=0; it clears otherwise.
  - On the edge ending the TIMEOUT-th consecutive such cycle: FIFO i is flushed (pointers 0, empty), soft_reset[i]=1 for the following cycle, and the counter clears.
  - A flush beats any write or read on the same edge.
  - If i=dest and the FSM is in HDR_WR, PAYLOAD or PARITY, the FSM goes to DROP for the rest of the packet. If the edge that flushes also accepts the parity byte, drop is pulsed immediately instead.
- err and drop are never both asserted for the same packet. err is not evaluated for dropped packets.
- Latency: header is visible on vld_out 2 cycles after its accept edge. A payload byte is visible 1 cycle after its accept edge if the FIFO was empty.

Test Plan:
1. NUM_PORTS=3, FIFO_DEPTH=16. Send 0x0D, 0x11, 0x22, 0x33, 0x0D back-to-back -> vld_out=3'b010, err=0, drop=0. Reading port 1 for 5 cycles yields data_out 0x0D, 0x11, 0x22, 0x33, 0x0D, then vld_out[1]=0.
2. Same packet with parity 0xFF -> err=1 exactly one cycle (CHECK). All 5 bytes are still in FIFO1.
3. Header 0x07 (addr 3, L=1), 0xAA, parity 0xAD -> no FIFO writes, vld_out=0. drop pulses once after the parity accept; the next packet to port 0 routes normally.
4. Header 0x3C (addr 0, L=15) plus 15 payload bytes plus parity, no reads -> busy=1 once FIFO0 holds 16 entries. One read of 0x3C drops busy the next cycle; the parity byte is then accepted and err=0.
5. Packet to port 2, read_enb[2]=0 -> soft_reset[2] pulses after 30 valid cycles and vld_out[2]=0. Repeat with the flush occurring mid-payload -> drop pulses at packet end, and no err.
6. resetn=0 mid-PAYLOAD -> all outputs 0 immediately and all FIFOs empty. After release, a fresh 0x0D packet routes correctly.
